control_sequencer: RTL and testbench

State-holding half of the multi-cycle datapath controller. It registers the 4-bit next-state code produced by the combinational next-state logic and returns the current state to it. It also gates sequencing with start/abort/stall controls and guards the S9->S3 loop with an iteration limit. It decodes the registered state into the datapath control word and reports busy/done/error status to the top level.

---
 rtl/ctrl_pkg.sv | 43 ++++
 rtl/ctrl_decode.sv | 30 +++
 rtl/control_sequencer.sv | 108 ++++++++++
 tb/tb_control_sequencer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared state codes, control-word table and write-enable mask for the
// multi-cycle datapath controller. One table serves the sequencer, the
// next-state logic and any datapath benches that need the decode.
package ctrl_pkg;

   localparam int ST_W   = 4;
   localparam int CTRL_W = 16;

   localparam logic [ST_W-1:0] S0  = 4'd0;
   localparam logic [ST_W-1:0] S1  = 4'd1;
   localparam logic [ST_W-1:0] S2  = 4'd2;
   localparam logic [ST_W-1:0] S3  = 4'd3;
   localparam logic [ST_W-1:0] S4  = 4'd4;
   localparam logic [ST_W-1:0] S5  = 4'd5;
   localparam logic [ST_W-1:0] S6  = 4'd6;
   localparam logic [ST_W-1:0] S7  = 4'd7;
   localparam logic [ST_W-1:0] S8  = 4'd8;
   localparam logic [ST_W-1:0] S9  = 4'd9;
   localparam logic [ST_W-1:0] S10 = 4'd10;

   // Control word emitted while idle; also the fallback for unused codes.
   localparam logic [CTRL_W-1:0] IDLE_CW = 16'h0000;

   // Bits [3:0] are the register-file and memory write enables; a stall
   // must never let one of these fire while the state is frozen.
   localparam logic [CTRL_W-1:0] WE_MASK = 16'h000F;

   // Per-state datapath control bits, indexed by state code.
   localparam logic [CTRL_W-1:0] CTRL_ROM [0:10] = '{
      16'h0000,   // S0  idle
      16'h8011,   // S1
      16'h4102,   // S2
      16'h2204,   // S3  loop head
      16'h1308,   // S4
      16'h0C41,   // S5
      16'h0A8F,   // S6
      16'h05C3,   // S7
      16'h0336,   // S8
      16'h01E9,   // S9  loop tail
      16'h00F1    // S10 completion
   };

endpackage

// File: rtl/ctrl_decode.sv
// Moore decode of the registered state into the datapath control word.
// Zero latency: purely combinational from the state register.
// During a stall the write enables are forced low so nothing commits.
module ctrl_decode
   import ctrl_pkg::*;
(
   input  logic [ST_W-1:0]   State_i,
   input  logic              Stall_i,
   output logic [CTRL_W-1:0] ControlWord_o
);

   logic [CTRL_W-1:0] w_raw_cw;

   // Table lookup; codes above S10 only appear after a fault, so emit idle.
   always_comb begin
      w_raw_cw = IDLE_CW;
      if (State_i <= S10) begin
         w_raw_cw = CTRL_ROM[State_i];
      end
   end

   // Mask write enables while the sequencer is frozen.
   always_comb begin
      ControlWord_o = w_raw_cw;
      if (Stall_i) begin
         ControlWord_o = w_raw_cw & ~WE_MASK;
      end
   end

endmodule

// File: rtl/control_sequencer.sv
// State register, loop-back iteration guard and status flags of the controller.
// State and flags update one edge after inputs; control word is same-cycle.
// Stall_i freezes state/counter/flags; Abort_i returns to S0 at the next edge.
module control_sequencer
   import ctrl_pkg::*;
#(
   parameter int STATE_W  = 4,
   parameter int CW_W     = 16,
   parameter int ITER_W   = 8,
   parameter int MAX_ITER = 255
)
(
   input  logic               Clk_i,
   input  logic               Rst_i,
   input  logic               Start_i,
   input  logic               Abort_i,
   input  logic               Stall_i,
   input  logic [STATE_W-1:0] NextState_i,
   output logic [STATE_W-1:0] CurrentState_o,
   output logic [CW_W-1:0]    ControlWord_o,
   output logic               Busy_o,
   output logic               Done_o,
   output logic [ITER_W-1:0]  IterCount_o,
   output logic               Overflow_o,
   output logic               Error_o
);

   logic [STATE_W-1:0] r_state;
   logic [ITER_W-1:0]  r_iter;
   logic               r_done;
   logic               r_ovf;
   logic               r_err;

   logic               w_illegal;
   logic               w_loop_back;
   logic               w_at_limit;

   // Classify the incoming next-state code against the current state.
   always_comb begin
      w_illegal   = (NextState_i > S10);
      w_loop_back = (r_state == S9) && (NextState_i == S3);
      w_at_limit  = (r_iter == ITER_W'(MAX_ITER));
   end

   // Sequencing FSM: reset > abort > stall > normal next-state loading.
   always_ff @(posedge Clk_i or posedge Rst_i) begin
      if (Rst_i) begin
         r_state <= S0;
         r_iter  <= '0;
         r_done  <= 1'b0;
         r_ovf   <= 1'b0;
         r_err   <= 1'b0;
      end else if (Abort_i) begin
         r_state <= S0;
         r_done  <= 1'b0;
      end else if (Stall_i) begin
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (r_state == S0) begin
            if (Start_i) begin
               // A new run clears last run's counter and sticky flags.
               r_iter <= '0;
               r_ovf  <= 1'b0;
               if (w_illegal) begin
                  r_err   <= 1'b1;
                  r_state <= S0;
               end else begin
                  r_err   <= 1'b0;
                  r_state <= NextState_i;
               end
            end
         end else if (w_illegal) begin
            r_state <= S0;
            r_err   <= 1'b1;
         end else if (w_loop_back) begin
            if (w_at_limit) begin
               // Limit reached: finish the run instead of looping again.
               r_state <= S10;
               r_ovf   <= 1'b1;
            end else begin
               r_state <= S3;
               r_iter  <= r_iter + 1'b1;
            end
         end else begin
            r_state <= NextState_i;
            r_done  <= (r_state == S10) && (NextState_i == S0);
         end
      end
   end

   ctrl_decode u_decode (
      .State_i       (r_state),
      .Stall_i       (Stall_i),
      .ControlWord_o (ControlWord_o)
   );

   // Status outputs straight from the registers.
   always_comb begin
      CurrentState_o = r_state;
      Busy_o         = (r_state != S0);
      Done_o         = r_done;
      IterCount_o    = r_iter;
      Overflow_o     = r_ovf;
      Error_o        = r_err;
   end

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

   localparam int MAXI = 3;

   logic        Clk_i = 1'b0;
   logic        Rst_i = 1'b1;
   logic        Start_i = 1'b0;
   logic        Abort_i = 1'b0;
   logic        Stall_i = 1'b0;
   logic [3:0]  NextState_i = 4'd0;
   logic [3:0]  CurrentState_o;
   logic [15:0] ControlWord_o;
   logic        Busy_o;
   logic        Done_o;
   logic [7:0]  IterCount_o;
   logic        Overflow_o;
   logic        Error_o;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: abstract run state
   int   m_state;
   int   m_iter;
   bit   m_done, m_ovf, m_err;
   logic [15:0] rom [0:10];
   logic [15:0] pre_cw_obs, pre_cw_exp;

   control_sequencer #(.STATE_W(4), .CW_W(16), .ITER_W(8), .MAX_ITER(MAXI)) dut (
      .Clk_i(Clk_i), .Rst_i(Rst_i), .Start_i(Start_i), .Abort_i(Abort_i),
      .Stall_i(Stall_i), .NextState_i(NextState_i),
      .CurrentState_o(CurrentState_o), .ControlWord_o(ControlWord_o),
      .Busy_o(Busy_o), .Done_o(Done_o), .IterCount_o(IterCount_o),
      .Overflow_o(Overflow_o), .Error_o(Error_o)
   );

   always #5 Clk_i = ~Clk_i;

   function automatic logic [15:0] exp_cw(input int s, input bit stall);
      logic [15:0] v;
      v = (s >= 0 && s <= 10) ? rom[s] : 16'h0000;
      if (stall) v = v & 16'hFFF0;
      return v;
   endfunction

   // Plausible next-state logic: a straight walk S1..S10 back to S0.
   function automatic logic [3:0] natural_ns(input int s);
      return (s >= 10) ? 4'd0 : 4'(s + 1);
   endfunction

   task automatic model_reset();
      m_state = 0; m_iter = 0; m_done = 0; m_ovf = 0; m_err = 0;
   endtask

   // Apply one clock edge of behaviour to the model.
   task automatic model_step(input bit st, input bit ab, input bit sl, input int ns);
      m_done = 0;
      if (ab) begin
         m_state = 0;
      end else if (sl) begin
         // everything holds
      end else if (m_state == 0) begin
         if (st) begin
            m_iter = 0; m_ovf = 0; m_err = (ns > 10);
            m_state = (ns > 10) ? 0 : ns;
         end
      end else if (ns > 10) begin
         m_state = 0; m_err = 1;
      end else if (m_state == 9 && ns == 3) begin
         if (m_iter < MAXI) begin m_state = 3; m_iter++; end
         else begin m_state = 10; m_ovf = 1; end
      end else begin
         m_done = (m_state == 10 && ns == 0);
         m_state = ns;
      end
   endtask

   // Drive one cycle's inputs, capture the pre-edge control word, advance.
   task automatic tick(input bit st, input bit ab, input bit sl, input logic [3:0] ns);
      @(negedge Clk_i);
      Start_i = st; Abort_i = ab; Stall_i = sl; NextState_i = ns;
      #1;
      pre_cw_obs = ControlWord_o;
      pre_cw_exp = exp_cw(m_state, sl);
      model_step(st, ab, sl, int'(ns));
      @(posedge Clk_i);
      #1;
   endtask

   task automatic go_idle();
      tick(0, 1, 0, 4'd0);
   endtask

   task automatic run_to(input int target);
      tick(1, 0, 0, 4'd1);
      while (m_state != target && m_state != 0) tick(0, 0, 0, natural_ns(m_state));
   endtask

   task automatic test_reset();
      #3;
      n_cmp++;
      if ({CurrentState_o, IterCount_o, Done_o, Overflow_o, Error_o, Busy_o, ControlWord_o} !== 31'd0) begin
         $display("FAIL reset_state: got st=%0d it=%0d dn=%b ov=%b er=%b bz=%b cw=%h, need all zero",
                  CurrentState_o, IterCount_o, Done_o, Overflow_o, Error_o, Busy_o, ControlWord_o);
         n_err++;
      end
      @(negedge Clk_i);
      Rst_i = 1'b0;
      model_reset();
   endtask

   task automatic test_normal_run();
      go_idle();
      tick(1, 0, 0, 4'd1);
      for (int k = 1; k <= 10; k++) begin
         n_cmp++;
         if (CurrentState_o !== 4'(k) || Busy_o !== 1'b1 || Done_o !== 1'b0) begin
            $display("FAIL run_seq: step %0d got st=%0d bz=%b dn=%b, need st=%0d bz=1 dn=0",
                     k, CurrentState_o, Busy_o, Done_o, k);
            n_err++;
         end
         n_cmp++;
         if (ControlWord_o !== rom[k]) begin
            $display("FAIL run_cw: state %0d got %h need %h", k, ControlWord_o, rom[k]);
            n_err++;
         end
         tick(1, 0, 0, natural_ns(k));
      end
      n_cmp++;
      if (CurrentState_o !== 4'd0 || Done_o !== 1'b1 || IterCount_o !== 8'd0 || Busy_o !== 1'b0) begin
         $display("FAIL run_done: got st=%0d dn=%b it=%0d bz=%b, need st=0 dn=1 it=0 bz=0",
                  CurrentState_o, Done_o, IterCount_o, Busy_o);
         n_err++;
      end
   endtask

   task automatic test_back_to_back();
      // Start still held: exactly one idle cycle, then S1.
      tick(1, 0, 0, 4'd1);
      n_cmp++;
      if (CurrentState_o !== 4'd1 || Done_o !== 1'b0) begin
         $display("FAIL back_to_back: got st=%0d dn=%b, need st=1 dn=0", CurrentState_o, Done_o);
         n_err++;
      end
      go_idle();
   endtask

   task automatic test_loop_limit();
      go_idle();
      run_to(9);
      for (int i = 1; i <= MAXI; i++) begin
         tick(0, 0, 0, 4'd3);
         n_cmp++;
         if (CurrentState_o !== 4'd3 || IterCount_o !== 8'(i) || Overflow_o !== 1'b0) begin
            $display("FAIL loop_back: pass %0d got st=%0d it=%0d ov=%b, need st=3 it=%0d ov=0",
                     i, CurrentState_o, IterCount_o, Overflow_o, i);
            n_err++;
         end
         for (int s = 3; s < 9; s++) tick(0, 0, 0, 4'(s + 1));
      end
      tick(0, 0, 0, 4'd3);
      n_cmp++;
      if (CurrentState_o !== 4'd10 || Overflow_o !== 1'b1 || IterCount_o !== 8'(MAXI)) begin
         $display("FAIL loop_limit: got st=%0d ov=%b it=%0d, need st=10 ov=1 it=%0d",
                  CurrentState_o, Overflow_o, IterCount_o, MAXI);
         n_err++;
      end
      tick(0, 0, 0, 4'd0);
      n_cmp++;
      if (CurrentState_o !== 4'd0 || Done_o !== 1'b1 || Overflow_o !== 1'b1) begin
         $display("FAIL ovf_done: got st=%0d dn=%b ov=%b, need st=0 dn=1 ov=1",
                  CurrentState_o, Done_o, Overflow_o);
         n_err++;
      end
   endtask

   task automatic test_stall();
      go_idle();
      run_to(6);
      for (int c = 0; c < 4; c++) begin
         tick(0, 0, 1, 4'd7);
         n_cmp++;
         if (CurrentState_o !== 4'd6 || pre_cw_obs !== (rom[6] & 16'hFFF0)) begin
            $display("FAIL stall_hold: cyc %0d got st=%0d cw=%h, need st=6 cw=%h",
                     c, CurrentState_o, pre_cw_obs, rom[6] & 16'hFFF0);
            n_err++;
         end
      end
      tick(0, 0, 0, 4'd7);
      n_cmp++;
      if (CurrentState_o !== 4'd7 || pre_cw_obs !== rom[6]) begin
         $display("FAIL stall_release: got st=%0d cw=%h, need st=7 cw=%h",
                  CurrentState_o, pre_cw_obs, rom[6]);
         n_err++;
      end
   endtask

   task automatic test_error();
      go_idle();
      run_to(4);
      tick(0, 0, 0, 4'd13);
      n_cmp++;
      if (CurrentState_o !== 4'd0 || Error_o !== 1'b1 || Done_o !== 1'b0) begin
         $display("FAIL error_exit: got st=%0d er=%b dn=%b, need st=0 er=1 dn=0",
                  CurrentState_o, Error_o, Done_o);
         n_err++;
      end
      tick(1, 0, 0, 4'd1);
      n_cmp++;
      if (CurrentState_o !== 4'd1 || Error_o !== 1'b0) begin
         $display("FAIL error_clear: got st=%0d er=%b, need st=1 er=0", CurrentState_o, Error_o);
         n_err++;
      end
   endtask

   task automatic test_abort_stall();
      go_idle();
      run_to(8);
      tick(0, 1, 1, 4'd9);
      n_cmp++;
      if (CurrentState_o !== 4'd0 || Done_o !== 1'b0 || Busy_o !== 1'b0) begin
         $display("FAIL abort_stall: got st=%0d dn=%b bz=%b, need st=0 dn=0 bz=0",
                  CurrentState_o, Done_o, Busy_o);
         n_err++;
      end
   endtask

   task automatic test_reset_mid_run();
      go_idle();
      run_to(5);
      #2;
      Rst_i = 1'b1;
      #1;
      n_cmp++;
      if (CurrentState_o !== 4'd0 || Busy_o !== 1'b0 || ControlWord_o !== 16'h0000 ||
          IterCount_o !== 8'd0 || {Done_o, Overflow_o, Error_o} !== 3'b000) begin
         $display("FAIL reset_async: got st=%0d bz=%b cw=%h it=%0d, need all zero",
                  CurrentState_o, Busy_o, ControlWord_o, IterCount_o);
         n_err++;
      end
      model_reset();
      @(negedge Clk_i);
      Rst_i = 1'b0;
   endtask

   task automatic test_random();
      logic [3:0] ns;
      bit st, ab, sl;
      int r;
      go_idle();
      for (int c = 0; c < 600; c++) begin
         ab = ($urandom_range(0, 99) < 3);
         sl = ($urandom_range(0, 99) < 12);
         st = ($urandom_range(0, 99) < 70);
         r  = $urandom_range(0, 99);
         if (r < 6)                    ns = 4'($urandom_range(0, 15));
         else if (m_state == 9 && r < 60) ns = 4'd3;
         else                          ns = natural_ns(m_state);
         tick(st, ab, sl, ns);
         n_cmp++;
         if ({CurrentState_o, IterCount_o, Done_o, Overflow_o, Error_o, Busy_o} !==
             {4'(m_state), 8'(m_iter), m_done, m_ovf, m_err, (m_state != 0)} ||
             ControlWord_o !== exp_cw(m_state, sl) || pre_cw_obs !== pre_cw_exp) begin
            $display("FAIL random: cyc %0d got st=%0d it=%0d dn=%b ov=%b er=%b cw=%h pre=%h, need st=%0d it=%0d dn=%b ov=%b er=%b cw=%h pre=%h",
                     c, CurrentState_o, IterCount_o, Done_o, Overflow_o, Error_o, ControlWord_o, pre_cw_obs,
                     m_state, m_iter, m_done, m_ovf, m_err, exp_cw(m_state, sl), pre_cw_exp);
            n_err++;
         end
      end
   endtask

   initial begin
      rom[0] = 16'h0000; rom[1] = 16'h8011; rom[2] = 16'h4102; rom[3]  = 16'h2204;
      rom[4] = 16'h1308; rom[5] = 16'h0C41; rom[6] = 16'h0A8F; rom[7]  = 16'h05C3;
      rom[8] = 16'h0336; rom[9] = 16'h01E9; rom[10] = 16'h00F1;
      model_reset();
      test_reset();
      test_normal_run();
      test_back_to_back();
      test_loop_limit();
      test_stall();
      test_error();
      test_abort_stall();
      test_reset_mid_run();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
